// File: rtl/ysyx_23060124_commit_ctrl.sv
// Commit controller: retires one instruction per handshake, sequencing GPR/CSR writes,
// the two-step ecall trap (mepc then mcause), mret return and fetch redirects.
module ysyx_23060124_commit_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
    input  logic        clock,
    input  logic        i_rst_n,
    // Handshake: a transfer happens on a rising edge where i_valid && o_ready;
    // o_ready is high only while idle, and every request field is sampled on that edge.
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_next,
    input  logic        i_wen,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_rd_wdata,
    input  logic        i_csr_wen,
    input  logic [11:0] i_csr_addr,
    input  logic [31:0] i_csr_wdata,
    input  logic        i_ecall,
    input  logic        i_mret,
    input  logic [31:0] i_mtvec,
    input  logic [31:0] i_mepc,
    output logic        o_gpr_wen,
    output logic [4:0]  o_gpr_waddr,
    output logic [31:0] o_gpr_wdata,
    output logic        o_csr_wen,
    output logic [11:0] o_csr_waddr,
    output logic [31:0] o_csr_wdata,
    output logic [31:0] o_pc,
    output logic        o_flush,
    output logic [63:0] o_minstret,
    output logic [2:0]  o_dbg_state
);

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COMMIT     = 3'd1,
        TRAP_EPC   = 3'd2,
        TRAP_CAUSE = 3'd3,
        REDIRECT   = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] mtvec_q;
    logic        ecall_q;

    assign o_dbg_state = state;

    // Strobes are registered on entry to the state that owns them, so each is
    // visible for exactly the one cycle the FSM spends in that state.
    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_ready     <= 1'b0;
            pc_q        <= 32'd0;
            mtvec_q     <= 32'd0;
            ecall_q     <= 1'b0;
            o_gpr_wen   <= 1'b0;
            o_gpr_waddr <= 5'd0;
            o_gpr_wdata <= 32'd0;
            o_csr_wen   <= 1'b0;
            o_csr_waddr <= 12'd0;
            o_csr_wdata <= 32'd0;
            o_pc        <= RESET_PC;
            o_flush     <= 1'b0;
            o_minstret  <= 64'd0;
        end else begin
            o_gpr_wen <= 1'b0;
            o_csr_wen <= 1'b0;
            o_flush   <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        pc_q    <= i_pc;
                        mtvec_q <= i_mtvec;
                        ecall_q <= i_ecall;
                        o_ready <= 1'b0;
                        if (i_ecall) begin
                            state       <= TRAP_EPC;
                            o_csr_wen   <= 1'b1;
                            o_csr_waddr <= CSR_MEPC;
                            o_csr_wdata <= i_pc;
                        end else if (i_mret) begin
                            state   <= REDIRECT;
                            o_pc    <= i_mepc;
                            o_flush <= 1'b1;
                        end else begin
                            state       <= COMMIT;
                            // x0 is hardwired to zero, so never present a write to it
                            o_gpr_wen   <= i_wen && (i_rd_addr != 5'd0);
                            o_gpr_waddr <= i_rd_addr;
                            o_gpr_wdata <= i_rd_wdata;
                            o_csr_wen   <= i_csr_wen;
                            o_csr_waddr <= i_csr_addr;
                            o_csr_wdata <= i_csr_wdata;
                            o_pc        <= i_pc_next;
                            o_flush     <= (i_pc_next != (i_pc + 32'd4));
                        end
                    end else begin
                        o_ready <= 1'b1;
                    end
                end
                COMMIT: begin
                    state      <= IDLE;
                    o_ready    <= 1'b1;
                    o_minstret <= o_minstret + 64'd1;
                end
                TRAP_EPC: begin
                    state       <= TRAP_CAUSE;
                    o_csr_wen   <= 1'b1;
                    o_csr_waddr <= CSR_MCAUSE;
                    o_csr_wdata <= ECALL_CAUSE;
                end
                TRAP_CAUSE: begin
                    state   <= REDIRECT;
                    o_pc    <= mtvec_q;
                    o_flush <= 1'b1;
                end
                REDIRECT: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                    // an ecall does not retire; only mret counts here
                    if (!ecall_q) o_minstret <= o_minstret + 64'd1;
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060124_commit_ctrl.sv
// Randomized scoreboard bench for the commit controller: a reference model queues the
// expected write/flush events per instruction and a monitor checks them as they appear.
module tb_ysyx_23060124_commit_ctrl;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] CAUSE    = 32'd11;
    localparam int          W        = 48;

    logic        clock;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_pc, i_pc_next;
    logic        i_wen;
    logic [4:0]  i_rd_addr;
    logic [31:0] i_rd_wdata;
    logic        i_csr_wen;
    logic [11:0] i_csr_addr;
    logic [31:0] i_csr_wdata;
    logic        i_ecall, i_mret;
    logic [31:0] i_mtvec, i_mepc;
    logic        o_gpr_wen;
    logic [4:0]  o_gpr_waddr;
    logic [31:0] o_gpr_wdata;
    logic        o_csr_wen;
    logic [11:0] o_csr_waddr;
    logic [31:0] o_csr_wdata;
    logic [31:0] o_pc;
    logic        o_flush;
    logic [63:0] o_minstret;
    logic [2:0]  o_dbg_state;

    ysyx_23060124_commit_ctrl #(.RESET_PC(RESET_PC), .ECALL_CAUSE(CAUSE)) dut (
        .clock(clock), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_pc_next(i_pc_next), .i_wen(i_wen), .i_rd_addr(i_rd_addr),
        .i_rd_wdata(i_rd_wdata), .i_csr_wen(i_csr_wen), .i_csr_addr(i_csr_addr),
        .i_csr_wdata(i_csr_wdata), .i_ecall(i_ecall), .i_mret(i_mret),
        .i_mtvec(i_mtvec), .i_mepc(i_mepc), .o_gpr_wen(o_gpr_wen),
        .o_gpr_waddr(o_gpr_waddr), .o_gpr_wdata(o_gpr_wdata), .o_csr_wen(o_csr_wen),
        .o_csr_waddr(o_csr_waddr), .o_csr_wdata(o_csr_wdata), .o_pc(o_pc),
        .o_flush(o_flush), .o_minstret(o_minstret), .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  m_pc;
    logic [63:0]  m_minstret;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ev_gpr(input logic [4:0] a, input logic [31:0] d);
        return {4'd1, 7'd0, a, d};
    endfunction
    function automatic logic [W-1:0] ev_csr(input logic [11:0] a, input logic [31:0] d);
        return {4'd2, a, d};
    endfunction
    function automatic logic [W-1:0] ev_flush(input logic [31:0] target);
        return {4'd3, 12'd0, target};
    endfunction

    task automatic observe(input string name, input logic [W-1:0] ev);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected event=%0h expected=none", name, ev);
        end else begin
            check(name, ev, exp_q.pop_front());
        end
    endtask

    // monitor: every presented strobe must match the head of the expected queue
    initial begin
        forever begin
            @(negedge clock);
            if (o_gpr_wen) observe("gpr_write", ev_gpr(o_gpr_waddr, o_gpr_wdata));
            if (o_csr_wen) observe("csr_write", ev_csr(o_csr_waddr, o_csr_wdata));
            if (o_flush)   observe("flush", ev_flush(o_pc));
        end
    end

    // ---------------- driver ----------------
    task automatic scramble_inputs();
        i_pc        = $urandom;
        i_pc_next   = $urandom;
        i_wen       = 1'($urandom_range(0, 1));
        i_rd_addr   = 5'($urandom);
        i_rd_wdata  = $urandom;
        i_csr_wen   = 1'($urandom_range(0, 1));
        i_csr_addr  = 12'($urandom);
        i_csr_wdata = $urandom;
        i_ecall     = 1'($urandom_range(0, 1));
        i_mret      = 1'($urandom_range(0, 1));
        i_mtvec     = $urandom;
        i_mepc      = $urandom;
    endtask

    // Called at a negedge; returns at the negedge where the controller is idle again.
    task automatic issue(input logic [31:0] pc, input logic [31:0] pc_next,
                         input logic wen, input logic [4:0] rd, input logic [31:0] wd,
                         input logic csr_wen, input logic [11:0] ca, input logic [31:0] cd,
                         input logic ecall, input logic mret,
                         input logic [31:0] mtvec, input logic [31:0] mepc);
        int       wait_cnt = 0;
        int       busy = 0;
        int       exp_busy;
        logic     e_gpr, e_csr, e_flush;
        i_pc = pc; i_pc_next = pc_next; i_wen = wen; i_rd_addr = rd; i_rd_wdata = wd;
        i_csr_wen = csr_wen; i_csr_addr = ca; i_csr_wdata = cd;
        i_ecall = ecall; i_mret = mret; i_mtvec = mtvec; i_mepc = mepc;
        i_valid = 1'b1;
        while (!o_ready && wait_cnt < 50) begin
            @(negedge clock);
            wait_cnt++;
        end
        if (!o_ready) begin
            check("ready_timeout", 64'(o_ready), 64'd1);
            i_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        i_valid = 1'b0;
        scramble_inputs();
        // reference model of one retirement
        if (ecall) begin
            exp_q.push_back(ev_csr(12'h341, pc));
            exp_q.push_back(ev_csr(12'h342, CAUSE));
            exp_q.push_back(ev_flush(mtvec));
            m_pc = mtvec;
            exp_busy = 3;
            e_gpr = 1'b0; e_csr = 1'b1; e_flush = 1'b0;
        end else if (mret) begin
            exp_q.push_back(ev_flush(mepc));
            m_pc = mepc;
            m_minstret = m_minstret + 64'd1;
            exp_busy = 1;
            e_gpr = 1'b0; e_csr = 1'b0; e_flush = 1'b1;
        end else begin
            logic [31:0] seq_pc;
            seq_pc  = pc + 32'd4;
            e_gpr   = wen && (rd != 5'd0);
            e_csr   = csr_wen;
            e_flush = (pc_next != seq_pc);
            if (e_gpr)   exp_q.push_back(ev_gpr(rd, wd));
            if (e_csr)   exp_q.push_back(ev_csr(ca, cd));
            if (e_flush) exp_q.push_back(ev_flush(pc_next));
            m_pc = pc_next;
            m_minstret = m_minstret + 64'd1;
            exp_busy = 1;
        end
        @(negedge clock);
        check("first_gpr_wen", 64'(o_gpr_wen), 64'(e_gpr));
        check("first_csr_wen", 64'(o_csr_wen), 64'(e_csr));
        check("first_flush", 64'(o_flush), 64'(e_flush));
        while (!o_ready && busy < 20) begin
            busy++;
            @(negedge clock);
        end
        check("busy_cycles", 64'(busy), 64'(exp_busy));
        check("arch_pc", 64'(o_pc), 64'(m_pc));
        check("minstret", o_minstret, m_minstret);
    endtask

    task automatic issue_normal(input logic [31:0] pc, input logic [31:0] pc_next,
                                input logic wen, input logic [4:0] rd, input logic [31:0] wd);
        issue(pc, pc_next, wen, rd, wd, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 64'(o_ready), 64'd0);
        check({tag, "_pc"}, 64'(o_pc), 64'(RESET_PC));
        check({tag, "_minstret"}, o_minstret, 64'd0);
        check({tag, "_strobes"}, {61'd0, o_gpr_wen, o_csr_wen, o_flush}, 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        scramble_inputs();
        m_pc = RESET_PC;
        m_minstret = 64'd0;
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        i_rst_n = 1'b1;
        @(negedge clock);
        check("ready_after_reset", 64'(o_ready), 64'd1);

        // directed cases
        issue_normal(32'h8000_0000, 32'h8000_0004, 1'b1, 5'd5, 32'd7);
        issue_normal(32'h8000_0010, 32'h8000_0000, 1'b0, 5'd0, 32'd0);
        issue(32'h8000_0020, 32'h8000_0024, 1'b1, 5'd3, 32'hdead, 1'b1, 12'h300, 32'h1,
              1'b1, 1'b0, 32'h8000_1000, 32'h0);
        issue(32'h8000_1000, 32'h8000_1004, 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0,
              1'b0, 1'b1, 32'h0, 32'h8000_0024);
        issue_normal(32'h8000_0024, 32'h8000_0028, 1'b1, 5'd0, 32'h1234);
        issue_normal(32'hffff_fffc, 32'h0000_0000, 1'b1, 5'd31, 32'hcafe_f00d);
        issue(32'h8000_0030, 32'h8000_0034, 1'b1, 5'd9, 32'h9, 1'b0, 12'd0, 32'd0,
              1'b1, 1'b1, 32'h8000_2000, 32'h8000_0040);
        issue(32'h8000_0040, 32'h8000_0044, 1'b1, 5'd10, 32'h55, 1'b1, 12'h305, 32'h8000_0100,
              1'b0, 1'b0, 32'h0, 32'h0);

        // randomized retirement stream
        for (int n = 0; n < 200; n++) begin
            logic [31:0] pc, pc_next;
            int          kind;
            pc = {$urandom, 2'b00} >> 0;
            pc = {pc[31:2], 2'b00};
            pc_next = ($urandom_range(0, 1) == 0) ? pc + 32'd4 : {$urandom_range(0, 32'hffff), 2'b00};
            kind = $urandom_range(0, 9);
            repeat ($urandom_range(0, 2)) @(negedge clock);
            issue(pc, pc_next, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  $urandom, 1'($urandom_range(0, 1)), 12'($urandom), $urandom,
                  (kind == 0 || kind == 2), (kind == 1 || kind == 2), $urandom, $urandom);
        end

        // reset while the trap is writing mcause: no 0x342 write, no redirect
        i_pc = 32'h8000_0050; i_pc_next = 32'h8000_0054; i_wen = 1'b0; i_csr_wen = 1'b0;
        i_ecall = 1'b1; i_mret = 1'b0; i_mtvec = 32'h8000_3000; i_mepc = 32'h0;
        i_valid = 1'b1;
        check("ready_before_trap", 64'(o_ready), 64'd1);
        @(posedge clock);
        #1;
        i_valid = 1'b0;
        exp_q.push_back(ev_csr(12'h341, 32'h8000_0050));
        @(posedge clock);
        #1;
        i_rst_n = 1'b0;
        m_pc = RESET_PC;
        m_minstret = 64'd0;
        #1;
        check_reset_values("midtrap_reset");
        repeat (2) @(negedge clock);
        i_rst_n = 1'b1;
        @(negedge clock);
        check("ready_after_midtrap", 64'(o_ready), 64'd1);
        check("pc_after_midtrap", 64'(o_pc), 64'(RESET_PC));
        issue_normal(32'h8000_0000, 32'h8000_0004, 1'b1, 5'd1, 32'h11);

        repeat (3) @(negedge clock);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
